// File: rtl/lif_layer_seq_if.sv
// rtl/lif_layer_seq_if.sv - timestep stream bundle for lif_layer_seq
// Ports (modports):
//   master: drives in_valid/in_spike, observes in_ready, out_valid, out_spike
//   slave : the layer; accepts in_valid/in_spike, drives in_ready, out_valid, out_spike
interface lif_layer_seq_if #(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_NEURONS = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_INPUTS-1:0]  in_spike;
    logic                   out_valid;
    logic [NUM_NEURONS-1:0] out_spike;

    modport master (
        output in_valid,
        output in_spike,
        input  in_ready,
        input  out_valid,
        input  out_spike
    );

    modport slave (
        input  in_valid,
        input  in_spike,
        output in_ready,
        output out_valid,
        output out_spike
    );
endinterface

// File: rtl/lif_layer_seq.sv
// rtl/lif_layer_seq.sv - time-multiplexed leaky-integrate-and-fire layer
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   bus (slave)            in_valid/in_ready/in_spike timestep input,
//                          out_valid pulse with out_spike result
//   threshold, leak_value  firing threshold and per-timestep leak (sampled in FIRE)
//   tref                   refractory timesteps after a spike (sampled in FIRE)
//   clear                  synchronous soft clear of potentials/refractory, aborts step
//   wr_en, wr_neuron, wr_input, wr_data   signed weight write port
//   pot_sel, pot_data      combinational potential readout
module lif_layer_seq #(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_NEURONS = 8,
    parameter int WEIGHT_W    = 8,
    parameter int POT_W       = 12,
    parameter int TREF_W      = 4,
    localparam int NW = $clog2(NUM_NEURONS),
    localparam int IW = $clog2(NUM_INPUTS)
) (
    input  logic                clk,
    input  logic                reset,
    lif_layer_seq_if.slave      bus,
    input  logic [POT_W-1:0]    threshold,
    input  logic [POT_W-1:0]    leak_value,
    input  logic [TREF_W-1:0]   tref,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [NW-1:0]       wr_neuron,
    input  logic [IW-1:0]       wr_input,
    input  logic [WEIGHT_W-1:0] wr_data,
    input  logic [NW-1:0]       pot_sel,
    output logic [POT_W-1:0]    pot_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INTEGRATE,
        S_FIRE,
        S_DONE
    } state_t;

    state_t                 state;
    logic [IW-1:0]          j;
    logic [NUM_INPUTS-1:0]  spikes;
    logic [POT_W-1:0]       pot    [NUM_NEURONS];
    logic [TREF_W-1:0]      refc   [NUM_NEURONS];
    logic [WEIGHT_W-1:0]    weight [NUM_NEURONS][NUM_INPUTS];

    // Two guard bits above the potential: the top bit flags a negative sum,
    // the next one an overflow past the largest potential.
    function automatic logic [POT_W-1:0] sat_add(input logic [POT_W-1:0]    p,
                                                  input logic [WEIGHT_W-1:0] wt);
        logic [POT_W+1:0] sum;
        sum = {2'b00, p} + {{(POT_W+2-WEIGHT_W){wt[WEIGHT_W-1]}}, wt};
        if (sum[POT_W+1])
            sat_add = '0;
        else if (sum[POT_W])
            sat_add = '1;
        else
            sat_add = sum[POT_W-1:0];
    endfunction

    always_comb begin
        pot_data = '0;
        if (int'(pot_sel) < NUM_NEURONS)
            pot_data = pot[pot_sel];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            j             <= '0;
            spikes        <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_spike <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                pot[n]  <= '0;
                refc[n] <= '0;
                for (int i = 0; i < NUM_INPUTS; i++)
                    weight[n][i] <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;

            // Writes land at the edge; an INTEGRATE read in the same cycle
            // still sees the previous weight.
            if (wr_en && (int'(wr_neuron) < NUM_NEURONS) && (int'(wr_input) < NUM_INPUTS))
                weight[wr_neuron][wr_input] <= wr_data;

            if (clear) begin
                state        <= S_IDLE;
                bus.in_ready <= 1'b1;
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    pot[n]  <= '0;
                    refc[n] <= '0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.in_valid) begin
                            spikes       <= bus.in_spike;
                            j            <= '0;
                            bus.in_ready <= 1'b0;
                            state        <= S_INTEGRATE;
                        end
                    end
                    S_INTEGRATE: begin
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            if (refc[n] == '0 && spikes[j])
                                pot[n] <= sat_add(pot[n], weight[n][j]);
                        end
                        if (j == IW'(NUM_INPUTS - 1))
                            state <= S_FIRE;
                        else
                            j <= j + 1'b1;
                    end
                    S_FIRE: begin
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            if (refc[n] != '0) begin
                                refc[n]          <= refc[n] - 1'b1;
                                pot[n]           <= '0;
                                bus.out_spike[n] <= 1'b0;
                            end else if (pot[n] >= threshold) begin
                                refc[n]          <= tref;
                                pot[n]           <= '0;
                                bus.out_spike[n] <= 1'b1;
                            end else begin
                                bus.out_spike[n] <= 1'b0;
                                if (pot[n] > leak_value)
                                    pot[n] <= pot[n] - leak_value;
                                else
                                    pot[n] <= '0;
                            end
                        end
                        state <= S_DONE;
                    end
                    S_DONE: begin
                        bus.out_valid <= 1'b1;
                        bus.in_ready  <= 1'b1;
                        state         <= S_IDLE;
                    end
                    default: begin
                        state        <= S_IDLE;
                        bus.in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lif_layer_seq.sv
// tb/tb_lif_layer_seq.sv - scoreboard bench for lif_layer_seq
module tb_lif_layer_seq;
    localparam int NI = 8;
    localparam int NN = 8;
    localparam int PMAX = 4095;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] threshold = '0;
    logic [11:0] leak_value = '0;
    logic [3:0]  tref = '0;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_neuron = '0;
    logic [2:0]  wr_input = '0;
    logic [7:0]  wr_data = '0;
    logic [2:0]  pot_sel = '0;
    logic [11:0] pot_data;

    lif_layer_seq_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) bus ();

    lif_layer_seq #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .WEIGHT_W(8), .POT_W(12), .TREF_W(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .threshold(threshold), .leak_value(leak_value), .tref(tref),
        .clear(clear), .wr_en(wr_en), .wr_neuron(wr_neuron), .wr_input(wr_input),
        .wr_data(wr_data), .pot_sel(pot_sel), .pot_data(pot_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [NN-1:0] spk;
        int            pot;
        int            acc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   acc = 0;

    int mw   [NN][NI];
    int mpot [NN];
    int mref [NN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset(input bit weights_too);
        for (int n = 0; n < NN; n++) begin
            mpot[n] = 0;
            mref[n] = 0;
            if (weights_too)
                for (int i = 0; i < NI; i++) mw[n][i] = 0;
        end
    endfunction

    // One whole timestep: serial saturating sum over active inputs, then
    // the refractory / threshold / leak decision.
    function automatic void model_step(input logic [NI-1:0] sp, input int ovn, input int ovj,
                                       input int ovw, output logic [NN-1:0] spk);
        int p;
        int wt;
        spk = '0;
        for (int n = 0; n < NN; n++) begin
            p = mpot[n];
            if (mref[n] == 0)
                for (int i = 0; i < NI; i++)
                    if (sp[i]) begin
                        wt = (n == ovn && i == ovj) ? ovw : mw[n][i];
                        p = p + wt;
                        if (p < 0) p = 0;
                        if (p > PMAX) p = PMAX;
                    end
            if (mref[n] != 0) begin
                mref[n]--;
                p = 0;
            end else if (p >= int'(threshold)) begin
                spk[n] = 1'b1;
                p = 0;
                mref[n] = int'(tref);
            end else begin
                p = (p > int'(leak_value)) ? p - int'(leak_value) : 0;
            end
            mpot[n] = p;
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("out_spike", bus.out_spike, mon_e.spk);
                chk("pot_data", pot_data, mon_e.pot);
                chk("latency", cyc - mon_e.acc, 10);
            end
        end
    end

    task automatic wr(input int n, input int i, input int v);
        wr_en = 1'b1;
        wr_neuron = n[2:0];
        wr_input = i[2:0];
        wr_data = v[7:0];
        @(posedge clk); #1;
        wr_en = 1'b0;
        mw[n][i] = v;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset(0);
    endtask

    // abort_kind: 0 none, 1 clear after edge acc+abort_at, 2 reset after edge acc+abort_at
    task automatic step(input logic [NI-1:0] sp, input bit expect_out = 1, input bit keep_valid = 0,
                        input int wr_n = -1, input int wr_col = 0, input int wr_at = 0,
                        input int wr_val = 0, input int abort_kind = 0, input int abort_at = 0);
        int     budget;
        int     ovw;
        exp_t   e;
        budget = 0;
        while (bus.in_ready !== 1'b1 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 100) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_spike = sp;
        @(posedge clk); #1;
        if (!keep_valid) bus.in_valid = 1'b0;
        acc = cyc;
        chk("in_ready_low_after_accept", bus.in_ready, 0);
        if (expect_out) begin
            ovw = 0;
            if (wr_n >= 0) ovw = (wr_at < wr_col) ? wr_val : mw[wr_n][wr_col];
            model_step(sp, wr_n, wr_col, ovw, e.spk);
            e.pot = mpot[pot_sel];
            e.acc = acc;
            q.push_back(e);
        end
        if (wr_n >= 0) begin
            repeat (wr_at) begin @(posedge clk); #1; end
            wr(wr_n, wr_col, wr_val);
        end
        if (abort_kind == 1) begin
            repeat (abort_at) begin @(posedge clk); #1; end
            do_clear();
            chk("clear_in_ready", bus.in_ready, 1);
            for (int n = 0; n < NN; n++) begin
                pot_sel = n[2:0];
                #1;
                chk("clear_pot_zero", pot_data, 0);
            end
            pot_sel = '0;
        end else if (abort_kind == 2) begin
            repeat (abort_at) begin @(posedge clk); #1; end
            reset = 1'b1;
            #1;
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 1);
            chk("rst_out_spike", bus.out_spike, 0);
            chk("rst_pot", pot_data, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            model_reset(1);
        end
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while ((q.size() != 0 || bus.in_ready !== 1'b1) && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        if (b >= 100) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int a0;
        int v;
        bus.in_valid = 1'b0;
        bus.in_spike = '0;
        model_reset(1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_spike", bus.out_spike, 0);
        chk("reset_pot", pot_data, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // refractory
        wr(0, 0, 7); wr(0, 1, 7);
        threshold = 9; leak_value = 1; tref = 2; pot_sel = 0;
        repeat (4) step(8'h03);
        wait_done();

        // leak
        wr(1, 2, 5);
        pot_sel = 1;
        step(8'h04); step(8'h04); step(8'h04); step(8'h00);
        wait_done();

        // negative saturation
        threshold = 4095; leak_value = 0; pot_sel = 2;
        wr(2, 0, 4);
        step(8'h01);
        wait_done();
        for (int i = 0; i < NI; i++) wr(2, i, -128);
        step(8'hFF);
        wait_done();

        // positive saturation
        for (int i = 0; i < NI; i++) wr(3, i, 127);
        pot_sel = 3;
        repeat (5) step(8'hFF);
        wait_done();

        // in_valid pulse during INTEGRATE is ignored
        step(8'hFF);
        repeat (3) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done();
        repeat (15) @(posedge clk);
        #1;

        // back-to-back with in_valid held
        pot_sel = 5;
        step(8'h5A, 1, 1); a0 = acc;
        step(8'hA5, 1, 1); chk("b2b_period", acc - a0, 11); a0 = acc;
        step(8'hFF, 1, 0); chk("b2b_period", acc - a0, 11);
        wait_done();

        // weight writes during INTEGRATE
        do_clear();
        threshold = 4095; leak_value = 0; pot_sel = 0;
        step(8'hFF, 1, 0, 0, 7, 2, 20);
        wait_done();
        step(8'hFF, 1, 0, 0, 3, 3, 10);
        wait_done();
        step(8'hFF);
        wait_done();

        // clear mid-INTEGRATE, then same-cycle clear + in_valid
        threshold = 9; leak_value = 1; tref = 2; pot_sel = 0;
        step(8'h03, 0, 0, -1, 0, 0, 0, 1, 4);
        clear = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; bus.in_valid = 1'b0;
        model_reset(0);
        chk("clear_wins_in_ready", bus.in_ready, 1);
        step(8'h03);
        wait_done();

        // randomized steps
        for (int k = 0; k < 40; k++) begin
            wait_done();
            repeat ($urandom_range(0, 4)) begin
                v = int'($urandom_range(0, 255)) - 128;
                wr(int'($urandom_range(0, NN - 1)), int'($urandom_range(0, NI - 1)), v);
            end
            threshold = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 600));
            leak_value = 12'($urandom_range(0, 40));
            tref = 4'($urandom_range(0, 3));
            pot_sel = 3'($urandom_range(0, NN - 1));
            step(NI'($urandom));
        end
        wait_done();

        // reset during FIRE wipes weights too
        step(8'hFF, 0, 0, -1, 0, 0, 0, 2, 8);
        threshold = 1; leak_value = 0; tref = 0; pot_sel = 3;
        step(8'hFF);
        wait_done();

        repeat (5) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
